// File: rtl/legv8_pkg.sv
// Shared constants for the LEGv8 core slice: ALU op codes, opcodes, ALUOP classes.
package legv8_pkg;

  localparam int DATA_W = 64;
  localparam int OPC_W  = 11;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
  localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
  localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
  localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
  localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
  localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
  // CBZ only fixes the top 8 bits; the low 3 are don't-care.
  localparam logic [7:0]       OPC_CBZ_HI = 8'b10110100;

  typedef enum logic [1:0] {
    ALUOP_MEM  = 2'b00,
    ALUOP_BR   = 2'b01,
    ALUOP_RTYP = 2'b10
  } aluop_e;

  // Field order {BRANCH,MEM2REG,REGWRITE,MEMWRITE,MEMREAD,ALUSRC,REG2LOC}.
  typedef struct packed {
    logic branch;
    logic mem2reg;
    logic regwrite;
    logic memwrite;
    logic memread;
    logic alusrc;
    logic reg2loc;
  } ctrl_t;

endpackage

// File: rtl/legv8_alu_core.sv
// 64-bit LEGv8 ALU; purely combinational, add/sub wrap modulo 2^64.
module legv8_alu_core
  import legv8_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] r
);

  always_comb begin
    r = '0;
    case (op)
      ALU_AND:   r = a & b;
      ALU_ORR:   r = a | b;
      ALU_ADD:   r = a + b;
      ALU_SUB:   r = a - b;
      ALU_PASSB: r = b;
      ALU_NOR:   r = ~(a | b);
      default:   r = '0;
    endcase
  end

endmodule

// File: rtl/legv8_core_unit.sv
// LEGv8 core slice: ALU, main controller and word-addressed data memory.
// Define ALU_ZERO_EN to add the ZERO flag output.
module legv8_core_unit
  import legv8_pkg::*;
#(
  parameter int MEM_DEPTH = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [63:0]       A,
  input  logic [63:0]       B,
  input  logic [3:0]        C,
  output logic [63:0]       R,
`ifdef ALU_ZERO_EN
  output logic              ZERO,
`endif
  input  logic [10:0]       INSTRUCTION,
  output logic              REG2LOC,
  output logic              ALUSRC,
  output logic              MEMREAD,
  output logic              MEMWRITE,
  output logic              REGWRITE,
  output logic              MEM2REG,
  output logic              BRANCH,
  output logic [1:0]        ALUOP,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic [63:0]       MEM_ADDR_IN,
  input  logic [63:0]       WRITE_DATA,
  output logic [63:0]       DATA_OUT
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  legv8_alu_core u_alu (
    .a  (A),
    .b  (B),
    .op (C),
    .r  (R)
  );

`ifdef ALU_ZERO_EN
  assign ZERO = (R == '0);
`endif

  ctrl_t  ctrl;
  aluop_e aluop;

  always_comb begin
    ctrl  = '0;
    aluop = ALUOP_MEM;
    if (INSTRUCTION[10:3] == OPC_CBZ_HI) begin
      ctrl  = 7'b1000001;
      aluop = ALUOP_BR;
    end else begin
      case (INSTRUCTION)
        OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR: begin
          ctrl  = 7'b0010000;
          aluop = ALUOP_RTYP;
        end
        OPC_LDUR: ctrl = 7'b0110110;
        OPC_STUR: ctrl = 7'b0001011;
        default:  ctrl = '0;
      endcase
    end
  end

  assign {BRANCH, MEM2REG, REGWRITE, MEMWRITE, MEMREAD, ALUSRC, REG2LOC} = ctrl;
  assign ALUOP = aluop;

  // Upper address bits are dropped so addresses wrap onto the array.
  logic [IDX_W-1:0] idx;
  logic             unused_addr_hi;
  assign idx            = MEM_ADDR_IN[IDX_W-1:0];
  assign unused_addr_hi = ^MEM_ADDR_IN[63:IDX_W];

  logic [63:0] mem [MEM_DEPTH];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (MEM_WRITE) begin
      mem[idx] <= WRITE_DATA;
    end
  end

  assign DATA_OUT = MEM_READ ? mem[idx] : '0;

endmodule

// File: tb/tb_legv8_core_unit.sv
// Directed bench for legv8_core_unit: ALU and controller tables plus memory sequences.
module tb_legv8_core_unit;

  localparam int DEPTH = 64;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] A, B;
  logic [3:0]  C;
  logic [63:0] R;
`ifdef ALU_ZERO_EN
  logic        ZERO;
`endif
  logic [10:0] INSTRUCTION;
  logic        REG2LOC, ALUSRC, MEMREAD, MEMWRITE, REGWRITE, MEM2REG, BRANCH;
  logic [1:0]  ALUOP;
  logic        MEM_READ, MEM_WRITE;
  logic [63:0] MEM_ADDR_IN, WRITE_DATA, DATA_OUT;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  legv8_core_unit #(.MEM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .C(C), .R(R),
`ifdef ALU_ZERO_EN
    .ZERO(ZERO),
`endif
    .INSTRUCTION(INSTRUCTION),
    .REG2LOC(REG2LOC), .ALUSRC(ALUSRC), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
    .REGWRITE(REGWRITE), .MEM2REG(MEM2REG), .BRANCH(BRANCH), .ALUOP(ALUOP),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR_IN(MEM_ADDR_IN),
    .WRITE_DATA(WRITE_DATA), .DATA_OUT(DATA_OUT)
  );

  typedef struct {
    logic [63:0] a, b;
    logic [3:0]  c;
    logic [63:0] r;
  } alu_vec_t;

  typedef struct {
    logic [10:0] instr;
    logic [6:0]  ctrl;
    logic [1:0]  aluop;
  } ctrl_vec_t;

  alu_vec_t  alu_tab [12];
  ctrl_vec_t ctl_tab [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    alu_tab[0]  = '{64'd5,  64'd5,  4'b0000, 64'd5};
    alu_tab[1]  = '{64'd10, 64'd10, 4'b0001, 64'd10};
    alu_tab[2]  = '{64'd43, 64'd27, 4'b0010, 64'd70};
    alu_tab[3]  = '{64'd43, 64'd27, 4'b0110, 64'd16};
    alu_tab[4]  = '{64'd43, 64'd27, 4'b0111, 64'd27};
    alu_tab[5]  = '{64'd0,  64'd1,  4'b0110, 64'hFFFF_FFFF_FFFF_FFFF};
    alu_tab[6]  = '{64'd0,  64'd0,  4'b1100, 64'hFFFF_FFFF_FFFF_FFFF};
    alu_tab[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0};
    alu_tab[8]  = '{64'hF0F0, 64'h0FF0, 4'b0000, 64'h00F0};
    alu_tab[9]  = '{64'hF000, 64'h000F, 4'b1100, 64'hFFFF_FFFF_FFFF_0FF0};
    alu_tab[10] = '{64'd43, 64'd27, 4'b0011, 64'd0};
    alu_tab[11] = '{64'd43, 64'd27, 4'b1111, 64'd0};

    ctl_tab[0] = '{11'b10001011000, 7'b0010000, 2'b10};
    ctl_tab[1] = '{11'b11001011000, 7'b0010000, 2'b10};
    ctl_tab[2] = '{11'b10001010000, 7'b0010000, 2'b10};
    ctl_tab[3] = '{11'b10101010000, 7'b0010000, 2'b10};
    ctl_tab[4] = '{11'b11111000010, 7'b0110110, 2'b00};
    ctl_tab[5] = '{11'b11111000000, 7'b0001011, 2'b00};
    ctl_tab[6] = '{11'b10110100101, 7'b1000001, 2'b01};
    ctl_tab[7] = '{11'b10110100000, 7'b1000001, 2'b01};
    ctl_tab[8] = '{11'b00000000000, 7'b0000000, 2'b00};
    ctl_tab[9] = '{11'b10110101000, 7'b0000000, 2'b00};

    RST = 1'b1; A = '0; B = '0; C = '0; INSTRUCTION = '0;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0; MEM_ADDR_IN = '0; WRITE_DATA = '0;
    tick();
    RST = 1'b0;

    // Reset state: every sampled address reads 0.
    MEM_READ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MEM_ADDR_IN = 64'(i * 17);
      #1 check($sformatf("reset_rd%0d", i), DATA_OUT, 64'd0);
    end
    MEM_READ = 1'b0;

    for (int i = 0; i < 12; i++) begin
      A = alu_tab[i].a; B = alu_tab[i].b; C = alu_tab[i].c;
      #1 check($sformatf("alu%0d", i), R, alu_tab[i].r);
    end

`ifdef ALU_ZERO_EN
    A = 64'd7; B = 64'd7; C = 4'b0110;
    #1 check("zero_set", {63'd0, ZERO}, 64'd1);
    A = 64'd8;
    #1 check("zero_clr", {63'd0, ZERO}, 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      INSTRUCTION = ctl_tab[i].instr;
      #1;
      check($sformatf("ctrl%0d", i),
            {57'd0, BRANCH, MEM2REG, REGWRITE, MEMWRITE, MEMREAD, ALUSRC, REG2LOC},
            {57'd0, ctl_tab[i].ctrl});
      check($sformatf("aluop%0d", i), {62'd0, ALUOP}, {62'd0, ctl_tab[i].aluop});
    end

    // Write with read disabled: output stays 0.
    MEM_WRITE = 1'b1; MEM_READ = 1'b0; MEM_ADDR_IN = 64'd2; WRITE_DATA = 64'h1234;
    #1 check("wr_rd_off", DATA_OUT, 64'd0);
    tick();
    check("wr_rd_off_post", DATA_OUT, 64'd0);
    MEM_WRITE = 1'b0; MEM_READ = 1'b1;
    #1 check("rd_addr2", DATA_OUT, 64'h1234);
    MEM_ADDR_IN = 64'd0;
    #1 check("rd_addr0", DATA_OUT, 64'd0);
    MEM_ADDR_IN = 64'd1;
    #1 check("rd_addr1", DATA_OUT, 64'd0);

    // Wrapped address, read-during-write: old word until the edge.
    MEM_ADDR_IN = 64'(DEPTH + 3); WRITE_DATA = 64'hABCD; MEM_WRITE = 1'b1;
    #1 check("rdw_old", DATA_OUT, 64'd0);
    tick();
    check("rdw_new", DATA_OUT, 64'hABCD);
    MEM_WRITE = 1'b0; MEM_ADDR_IN = 64'd3;
    #1 check("wrap_rd3", DATA_OUT, 64'hABCD);
    MEM_ADDR_IN = 64'd2;
    #1 check("rd_addr2_kept", DATA_OUT, 64'h1234);

    // Reset beats a simultaneous write.
    RST = 1'b1; MEM_WRITE = 1'b1; MEM_ADDR_IN = 64'd3; WRITE_DATA = 64'h5555;
    tick();
    RST = 1'b0; MEM_WRITE = 1'b0;
    #1 check("rst_prio3", DATA_OUT, 64'd0);
    MEM_ADDR_IN = 64'd2;
    #1 check("rst_clr2", DATA_OUT, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
